// File: rtl/enc_pkg.sv
// Shared types and helpers for the round-robin priority encoder.
//   enc_state_e : result-register occupancy (EMPTY / FULL)
//   idx_w()     : index width for a W-line request vector
//   ptr_inc()   : advance the priority pointer with an explicit wrap at W-1
package enc_pkg;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } enc_state_e;

  // Index width for w request lines. Never below 1 bit.
  function automatic int idx_w(input int w);
    if (w <= 1) begin
      return 1;
    end else begin
      return $clog2(w);
    end
  endfunction

  // Next pointer after granting index idx. The wrap is explicit so that a
  // non-power-of-two w never leaves the pointer at a value >= w.
  function automatic int unsigned ptr_inc(input int unsigned idx, input int unsigned w);
    if (idx >= w - 32'd1) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/enc_rr_sel.sv
// Combinational round-robin select.
//   i_req   : multi-hot request vector
//   i_ptr   : current priority position (0..W-1)
//   o_grant : one-hot grant, or all-zero when i_req is zero
// The first pass looks only at requests at or above i_ptr; if none are set,
// the second, unmasked pass wraps around to the lowest request overall.
module enc_rr_sel
  import enc_pkg::*;
#(
  parameter  int W     = 8,
  localparam int IDX_W = idx_w(W)
) (
  input  logic [W-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [W-1:0]     o_grant
);

  logic [W-1:0] mask_s;
  logic [W-1:0] masked_s;
  logic [W-1:0] lsb_masked_s;
  logic [W-1:0] lsb_all_s;

  // Thermometer mask: ones at and above the pointer.
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < W; i++) begin
      mask_s[i] = (i >= int'(i_ptr));
    end
  end

  assign masked_s = i_req & mask_s;

  // x & -x isolates the lowest set bit.
  assign lsb_masked_s = masked_s & (~masked_s + W'(1'b1));
  assign lsb_all_s    = i_req & (~i_req + W'(1'b1));

  // Prefer the masked pass; fall back to the wrap-around pass.
  always_comb begin
    if (|masked_s) begin
      o_grant = lsb_masked_s;
    end else begin
      o_grant = lsb_all_s;
    end
  end

endmodule

// File: rtl/enc_rr.sv
// Round-robin priority encoder with a registered, valid/ready output stage.
//   clk, arst      : clock, asynchronous active-high reset
//   i_vld, i_req   : request vector and its valid; o_rdy accepts it
//   o_vld, o_oh    : registered result valid and one-hot grant
//   o_idx          : registered binary index of the grant
//   i_rdy          : downstream consumes the result this cycle
//   i_lock         : only when ENC_RR_LOCK_EN is defined; an accept with
//                    i_lock=1 leaves the priority pointer where it is
// Optional build macro: ENC_RR_LOCK_EN.
module enc_rr
  import enc_pkg::*;
#(
  parameter  int W     = 8,
  localparam int IDX_W = idx_w(W)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             i_vld,
  input  logic [W-1:0]     i_req,
  output logic             o_rdy,
  output logic             o_vld,
  output logic [W-1:0]     o_oh,
  output logic [IDX_W-1:0] o_idx,
  input  logic             i_rdy
`ifdef ENC_RR_LOCK_EN
  ,
  input  logic             i_lock
`endif
);

  enc_state_e       state_q, state_d;
  logic [W-1:0]     oh_q, oh_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [W-1:0]     grant_s;
  logic [IDX_W-1:0] gidx_s;
  logic             accept_s;
  logic             lock_s;

`ifdef ENC_RR_LOCK_EN
  assign lock_s = i_lock;
`else
  assign lock_s = 1'b0;
`endif

  enc_rr_sel #(.W(W)) u_sel (
    .i_req   (i_req),
    .i_ptr   (ptr_q),
    .o_grant (grant_s)
  );

  // One-hot to binary: OR together the indices of set bits.
  always_comb begin
    gidx_s = '0;
    for (int i = 0; i < W; i++) begin
      if (grant_s[i]) begin
        gidx_s = gidx_s | IDX_W'(i);
      end else begin
        gidx_s = gidx_s;
      end
    end
  end

  assign o_vld    = (state_q == ST_FULL);
  assign o_rdy    = !o_vld | i_rdy;
  assign accept_s = i_vld & o_rdy;

  // Next-state: load on nonzero accept, drain on consume, otherwise hold.
  always_comb begin
    state_d = state_q;
    oh_d    = oh_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    if (accept_s && (|i_req)) begin
      state_d = ST_FULL;
      oh_d    = grant_s;
      idx_d   = gidx_s;
      if (lock_s) begin
        ptr_d = ptr_q;
      end else begin
        ptr_d = IDX_W'(ptr_inc(32'(gidx_s), 32'(W)));
      end
    end else if (i_rdy) begin
      // Consumed (or already empty) with nothing new to load.
      state_d = ST_EMPTY;
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= ST_EMPTY;
      oh_q    <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      oh_q    <= oh_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_oh  = oh_q;
  assign o_idx = idx_q;

endmodule

// File: tb/tb_enc_rr.sv
module tb_enc_rr;

  logic       clk = 1'b0;
  logic       arst = 1'b1;

  logic       vld8 = 1'b0, rdy8 = 1'b0;
  logic [7:0] req8 = 8'h00;
  logic       ordy8, ovld8;
  logic [7:0] oh8;
  logic [2:0] idx8;

  logic       vld5 = 1'b0, rdy5 = 1'b0;
  logic [4:0] req5 = 5'h00;
  logic       ordy5, ovld5;
  logic [4:0] oh5;
  logic [2:0] idx5;

`ifdef ENC_RR_LOCK_EN
  logic       lock8 = 1'b0;
  logic       lock5 = 1'b0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  enc_rr #(.W(8)) u8 (
    .clk(clk), .arst(arst), .i_vld(vld8), .i_req(req8), .o_rdy(ordy8),
    .o_vld(ovld8), .o_oh(oh8), .o_idx(idx8), .i_rdy(rdy8)
`ifdef ENC_RR_LOCK_EN
    , .i_lock(lock8)
`endif
  );

  enc_rr #(.W(5)) u5 (
    .clk(clk), .arst(arst), .i_vld(vld5), .i_req(req5), .o_rdy(ordy5),
    .o_vld(ovld5), .o_oh(oh5), .o_idx(idx5), .i_rdy(rdy5)
`ifdef ENC_RR_LOCK_EN
    , .i_lock(lock5)
`endif
  );

  typedef struct {
    logic       vld;
    logic [7:0] req;
    logic       rdy;
    logic       e_rdy;
    logic       e_vld;
    logic [7:0] e_oh;
    logic [2:0] e_idx;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one W=8 cycle: check o_rdy before the edge, outputs after it.
  task automatic step8(input string name, input logic v, input logic [7:0] r, input logic rd,
                       input logic e_rdy, input logic e_vld, input logic [7:0] e_oh,
                       input logic [2:0] e_idx);
    vld8 = v; req8 = r; rdy8 = rd;
    #1;
    chk({name, ".o_rdy"}, 32'(ordy8), 32'(e_rdy));
    @(posedge clk); #1;
    chk({name, ".o_vld"}, 32'(ovld8), 32'(e_vld));
    chk({name, ".o_oh"},  32'(oh8),   32'(e_oh));
    chk({name, ".o_idx"}, 32'(idx8),  32'(e_idx));
  endtask

  task automatic step5(input string name, input logic [4:0] r,
                       input logic [4:0] e_oh, input logic [2:0] e_idx);
    vld5 = 1'b1; req5 = r; rdy5 = 1'b1;
    @(posedge clk); #1;
    chk({name, ".o_vld"}, 32'(ovld5), 32'd1);
    chk({name, ".o_oh"},  32'(oh5),   32'(e_oh));
    chk({name, ".o_idx"}, 32'(idx5),  32'(e_idx));
  endtask

  task automatic pulse_reset();
    #2 arst = 1'b1;
    #1;
    chk("arst.o_vld", 32'(ovld8), 32'd0);
    chk("arst.o_oh",  32'(oh8),   32'd0);
    chk("arst.o_idx", 32'(idx8),  32'd0);
    chk("arst.o_rdy", 32'(ordy8), 32'd1);
    #2 arst = 1'b0;
  endtask

  initial begin
    //         vld   req    rdy   e_rdy e_vld e_oh   e_idx
    tbl[0]  = '{1'b1, 8'hA4, 1'b1, 1'b1, 1'b1, 8'h04, 3'd2};
    tbl[1]  = '{1'b1, 8'hA4, 1'b1, 1'b1, 1'b1, 8'h20, 3'd5};
    tbl[2]  = '{1'b1, 8'hA4, 1'b1, 1'b1, 1'b1, 8'h80, 3'd7};
    tbl[3]  = '{1'b1, 8'hA4, 1'b1, 1'b1, 1'b1, 8'h04, 3'd2};   // wrap
    tbl[4]  = '{1'b1, 8'h40, 1'b1, 1'b1, 1'b1, 8'h40, 3'd6};   // ptr -> 7
    tbl[5]  = '{1'b1, 8'h81, 1'b1, 1'b1, 1'b1, 8'h80, 3'd7};   // ptr -> 0
    tbl[6]  = '{1'b1, 8'h81, 1'b1, 1'b1, 1'b1, 8'h01, 3'd0};   // ptr -> 1
    tbl[7]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h02, 3'd1};   // proves ptr=1
    tbl[8]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h02, 3'd1};   // zero req dropped
    tbl[9]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h04, 3'd2};   // ptr unchanged
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h04, 3'd2};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h04, 3'd2};   // empty -> ready
    tbl[12] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h08, 3'd3};
    tbl[13] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h08, 3'd3};   // full stall
    tbl[14] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h08, 3'd3};   // consume + zero
    tbl[15] = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 3'd0};   // ptr 4 wraps
    tbl[16] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h01, 3'd0};   // stall x3
    tbl[17] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h01, 3'd0};
    tbl[18] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h01, 3'd0};
    tbl[19] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h02, 3'd1};   // no bubble
    tbl[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h02, 3'd1};
    tbl[21] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h02, 3'd1};

    // Reset state.
    #1;
    chk("rst.o_vld", 32'(ovld8), 32'd0);
    chk("rst.o_oh",  32'(oh8),   32'd0);
    chk("rst.o_idx", 32'(idx8),  32'd0);
    chk("rst.o_rdy", 32'(ordy8), 32'd1);
    @(posedge clk); #1;
    arst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      step8($sformatf("tbl%0d", i), tbl[i].vld, tbl[i].req, tbl[i].rdy,
            tbl[i].e_rdy, tbl[i].e_vld, tbl[i].e_oh, tbl[i].e_idx);
    end

    // Reset while a result is pending: lost, and pointer back to 0.
    step8("pre_rst", 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h04, 3'd2);
    vld8 = 1'b0;
    pulse_reset();
    step8("post_rst", 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h01, 3'd0);

`ifdef ENC_RR_LOCK_EN
    vld8 = 1'b0;
    pulse_reset();
    lock8 = 1'b1;
    step8("lock0", 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h01, 3'd0);
    step8("lock1", 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h01, 3'd0);
    step8("lock2", 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h01, 3'd0);
    lock8 = 1'b0;
    step8("unlock0", 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h01, 3'd0);
    step8("unlock1", 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h02, 3'd1);
`endif
    vld8 = 1'b0;

    // W=5: explicit wrap from index 4.
    step5("w5_a", 5'b10000, 5'b10000, 3'd4);
    step5("w5_b", 5'b10001, 5'b00001, 3'd0);
    step5("w5_c", 5'b11111, 5'b00010, 3'd1);
    vld5 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/enc_rr.md
Name: enc_rr

Overview:
- Parametrised round-robin priority encoder with a registered output stage.
- Takes a multi-hot request vector each accepted cycle.
- Selects one request by rotating priority and emits both its one-hot form and its binary index.
- Sits ahead of arbitration and queue-select paths; the successor to the plain one-hot encoder, with wrap-around fairness and a valid/ready handshake.

Parameters:
- W, 8, number of request lines; W >= 2; need not be a power of two.
- IDX_W, $clog2(W), index width; derived, not to be overridden.

Ports:
- clk  input  1  clock; all state on rising edge.
- arst  input  1  asynchronous, active-high reset.
- i_vld  input  1  request vector valid.
- i_req  input  W  multi-hot request vector.
- o_rdy  output  1  block can accept i_req this cycle.
- o_vld  output  1  registered result valid.
- o_oh  output  W  one-hot grant (registered).
- o_idx  output  IDX_W  binary index of grant (registered).
- i_rdy  input  1  downstream consumes result this cycle.
- i_lock  input  1  present only with ENC_RR_LOCK_EN; hold priority pointer.

Behaviour:
- Reset (arst=1, asynchronous): o_vld=0, o_oh=0, o_idx=0, internal pointer ptr=0. o_rdy=1 after reset.
- o_rdy = !o_vld | i_rdy. Combinational; no path from i_vld to o_rdy.
- Accept = i_vld & o_rdy.
- Selection (combinational, same cycle as accept):
  - grant = lowest set bit of i_req at index >= ptr.
  - If none, grant = lowest set bit of i_req overall (wrap).
  - Two-pass masked/unmasked priority select.
- Accept with i_req != 0:
  - Next cycle: o_vld=1, o_oh=grant, o_idx=index(grant).
  - ptr <= index(grant)+1; if index(grant)==W-1 then ptr <= 0.
  - Wrap is explicit for non-power-of-two W; ptr never holds a value >= W.
- Accept with i_req == 0: vector dropped; o_vld <= 0 if i_rdy or !o_vld; ptr unchanged.
- No accept: if i_rdy & o_vld then o_vld <= 0; otherwise outputs hold.
- Output registers load only on accept; o_oh/o_idx stay stable while o_vld & !i_rdy.
- Latency: 1 cycle accept -> o_vld. Throughput: 1 result/cycle when i_rdy held high.
- Back-to-back: consume and accept in the same cycle replaces the result with no bubble.
- Invariants:
  - o_oh has exactly one bit set when o_vld=1.
  - o_idx always matches o_oh.
- Reset mid-operation clears a pending result immediately; the pending result is lost, not replayed.
- States: EMPTY (o_vld=0) / FULL (o_vld=1).
  - EMPTY -> FULL on accept with nonzero req.
  - FULL -> EMPTY on i_rdy without new nonzero accept.
  - FULL -> FULL on stall, or on i_rdy with new accept.

Optional Feature:
- ENC_RR_LOCK_EN defined:
  - i_lock port exists.
  - On an accept with i_lock=1, ptr is not updated; the same priority position is retained (burst lock).
  - Output behaviour is otherwise identical.
- Undefined: no i_lock port; ptr advances on every nonzero accept.

Decomposition:
- Package enc_pkg: idx_t width function, localparam-style helper for IDX_W, and function ptr_inc(idx, W) implementing the wrap rule.
- One sub-module enc_rr_sel (combinational):
  - Inputs i_req and ptr; outputs one-hot grant.
  - Built from mask generation plus two lowest-set-bit selects.
- Existing one-hot encoder produces o_idx from the grant.

Test Plan:
- W=8, reset, i_vld=1, i_req=8'b1010_0100, i_rdy=1 -> next cycle o_oh=8'h04, o_idx=2; then same req -> o_idx=5, then 7, then 2 (wrap).
- W=8, ptr driven to 7, i_req=8'b1000_0001 -> o_idx=7; next identical req -> o_idx=0, ptr=1.
- W=5, i_req=5'b1_0000 accepted -> o_idx=4, ptr wraps to 0; then i_req=5'b1_0001 -> o_idx=0.
- Stall: o_vld=1, i_rdy=0 for 3 cycles with new i_vld -> o_rdy=0, o_oh/o_idx unchanged, ptr unchanged; i_rdy=1 -> accept next in the same cycle, no bubble.
- i_req=0 with i_vld=1 -> o_vld stays 0, ptr unchanged; arst pulse while o_vld=1 -> o_vld=0 immediately, ptr=0.
- ENC_RR_LOCK_EN, i_lock=1, i_req=8'hFF accepted 3 times -> o_idx=0,0,0; drop i_lock -> o_idx=0 then 1.
